// File: rtl/mini_fu_arbiter.sv
// mini_fu_arbiter: round-robin arbiter feeding a two-stage pipeline around a shared 3-bit function unit
module mini_fu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] op,
  output logic [NREQ-1:0]   ack,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [2:0]        res_data,
  output logic [15:0]       done_cnt
);
  logic s1_valid, found, adv, can_accept;
  logic [IDW-1:0] s1_id, ptr, gnt, idx;
  logic [2:0] s1_op, gnt_op;
  logic [NREQ-1:0][2:0] ops;
  function automatic logic [2:0] fu(input logic [2:0] a);
    return {(a[2] & a[1]) | (a[2] & a[0]) | (a[1] & a[0]), ^a, ~a[0]};
  endfunction
  assign ops = op;
  assign adv = !res_valid || res_ready;
  assign can_accept = !s1_valid || adv;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    found = 1'b0;
    gnt = '0;
    gnt_op = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (req[idx]) begin
        found = 1'b1;
        gnt = idx;
        gnt_op = ops[idx];
      end
    end
  end
  always_comb begin
    ack = '0;
    if (found && can_accept && !rst) ack[gnt] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_op <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_data <= '0;
      ptr <= '0;
      done_cnt <= '0;
    end else begin
      if (adv) begin
        res_valid <= s1_valid;
        res_id <= s1_id;
        res_data <= fu(s1_op);
      end
      if (can_accept) begin
        s1_valid <= found;
        if (found) begin
          s1_id <= gnt;
          s1_op <= gnt_op;
          ptr <= (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
        end
      end
      if (res_valid && res_ready) done_cnt <= done_cnt + 16'd1;
    end
  end
endmodule
